// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - multi-cycle multiply/divide unit owning HI/LO; MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU
module ex_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [5:0]            funct,
  input  logic                  special2,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  input  logic                  flush,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  hi_q, hi_d;
  logic [DW-1:0]  lo_q, lo_d;
  logic [DW-1:0]  opa_q, opa_d;   // multiplicand, or dividend shifting into quotient
  logic [DW-1:0]  opb_q, opb_d;   // multiplier or divisor
  logic [DW-1:0]  rem_q, rem_d;   // partial remainder
  logic           neg_q, neg_d;   // product / quotient must be negated
  logic           rneg_q, rneg_d; // remainder must be negated
`ifdef MULDIV_MADD_EN
  logic           acc_q, acc_d;   // accumulate into {hi,lo} at completion
  logic           sub_q, sub_d;   // accumulate by subtraction
`endif

  logic dec_mult, dec_multu, dec_div, dec_divu;
  logic dec_mfhi, dec_mthi, dec_mflo, dec_mtlo;
  logic mul_start, mul_signed, div_start, div_signed;
  logic acc_start, acc_sub;
  logic div_by_zero, issue, last_iter;

  logic [DW-1:0]   op1_abs, op2_abs;
  logic [DW:0]     rem_sh, rem_diff;
  logic            q_bit;
  logic [DW-1:0]   rem_n, quo_n;
  logic [2*DW-1:0] prod_u, prod_s, mul_final;

  // Instruction decode and issue qualification
  always_comb begin
    dec_mult   = !special2 && (funct == 6'h18);
    dec_multu  = !special2 && (funct == 6'h19);
    dec_div    = !special2 && (funct == 6'h1A);
    dec_divu   = !special2 && (funct == 6'h1B);
    dec_mfhi   = !special2 && (funct == 6'h10);
    dec_mthi   = !special2 && (funct == 6'h11);
    dec_mflo   = !special2 && (funct == 6'h12);
    dec_mtlo   = !special2 && (funct == 6'h13);
    mul_start  = dec_mult | dec_multu;
    mul_signed = dec_mult;
    acc_start  = 1'b0;
    acc_sub    = 1'b0;
`ifdef MULDIV_MADD_EN
    acc_start  = special2 && ((funct == 6'h00) || (funct == 6'h01) ||
                              (funct == 6'h04) || (funct == 6'h05));
    acc_sub    = special2 && ((funct == 6'h04) || (funct == 6'h05));
    mul_start  = mul_start | acc_start;
    mul_signed = mul_signed | (special2 && ((funct == 6'h00) || (funct == 6'h04)));
`endif
    div_start   = dec_div | dec_divu;
    div_signed  = dec_div;
    div_by_zero = (operand_2 == '0);
    issue       = valid && !flush && (state_q == S_IDLE);
    last_iter   = (cnt_q == CW'(1));
  end

  // Operand magnitudes, one restoring-division step, and the final product
  always_comb begin
    op1_abs  = operand_1[DW-1] ? ('0 - operand_1) : operand_1;
    op2_abs  = operand_2[DW-1] ? ('0 - operand_2) : operand_2;
    rem_sh   = {rem_q, opa_q[DW-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    q_bit    = !rem_diff[DW];
    rem_n    = q_bit ? rem_diff[DW-1:0] : rem_sh[DW-1:0];
    quo_n    = {opa_q[DW-2:0], q_bit};
    prod_u   = {{DW{1'b0}}, opa_q} * {{DW{1'b0}}, opb_q};
    prod_s   = neg_q ? ('0 - prod_u) : prod_u;
`ifdef MULDIV_MADD_EN
    if (acc_q) begin
      mul_final = sub_q ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
    end else begin
      mul_final = prod_s;
    end
`else
    mul_final = prod_s;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue && mul_start)                      state_d = S_MUL;
          else if (issue && div_start && !div_by_zero) state_d = S_DIV;
        end
        S_MUL:   if (last_iter) state_d = S_IDLE;
        S_DIV:   if (last_iter) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: stall until the completing cycle, MF reads are combinational
  always_comb begin
    stall_req    = 1'b0;
    result       = '0;
    result_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_req = issue && (mul_start || (div_start && !div_by_zero));
        if (issue && dec_mfhi) begin
          result       = hi_q;
          result_valid = 1'b1;
        end else if (issue && dec_mflo) begin
          result       = lo_q;
          result_valid = 1'b1;
        end
      end
      S_MUL, S_DIV: stall_req = !flush && (cnt_q > CW'(1));
      default:      stall_req = 1'b0;
    endcase
    if (!rst_n) begin
      stall_req    = 1'b0;
      result_valid = 1'b0;
      result       = '0;
    end
  end

  // Datapath next values: operand capture, iteration, HI/LO commit
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    rem_d  = rem_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
`ifdef MULDIV_MADD_EN
    acc_d  = acc_q;
    sub_d  = sub_q;
`endif
    if (flush) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue && mul_start) begin
            opa_d = mul_signed ? op1_abs : operand_1;
            opb_d = mul_signed ? op2_abs : operand_2;
            neg_d = mul_signed && (operand_1[DW-1] ^ operand_2[DW-1]);
            cnt_d = CW'(MUL_CYCLES - 1);
`ifdef MULDIV_MADD_EN
            acc_d = acc_start;
            sub_d = acc_sub;
`endif
          end else if (issue && div_start) begin
            if (div_by_zero) begin
              lo_d = '1;
              hi_d = operand_1;
            end else begin
              opa_d  = div_signed ? op1_abs : operand_1;
              opb_d  = div_signed ? op2_abs : operand_2;
              rem_d  = '0;
              neg_d  = div_signed && (operand_1[DW-1] ^ operand_2[DW-1]);
              rneg_d = div_signed && operand_1[DW-1];
              cnt_d  = CW'(DW);
            end
          end else if (issue && dec_mthi) begin
            hi_d = operand_1;
          end else if (issue && dec_mtlo) begin
            lo_d = operand_1;
          end
        end
        S_MUL: begin
          cnt_d = cnt_q - CW'(1);
          if (last_iter) begin
            hi_d = mul_final[2*DW-1:DW];
            lo_d = mul_final[DW-1:0];
          end
        end
        S_DIV: begin
          cnt_d = cnt_q - CW'(1);
          opa_d = quo_n;
          rem_d = rem_n;
          if (last_iter) begin
            lo_d = neg_q ? ('0 - quo_n) : quo_n;
            hi_d = rneg_q ? ('0 - rem_n) : rem_n;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      rem_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_q  <= 1'b0;
      sub_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      rem_q  <= rem_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
`ifdef MULDIV_MADD_EN
      acc_q  <= acc_d;
      sub_q  <= sub_d;
`endif
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed table-driven bench for ex_muldiv (default parameters)
module tb_ex_muldiv;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [5:0]  funct;
  logic        special2;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        flush;
  logic        stall_req;
  logic [31:0] result;
  logic        result_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;

  ex_muldiv dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid        (valid),
    .funct        (funct),
    .special2     (special2),
    .operand_1    (operand_1),
    .operand_2    (operand_2),
    .flush        (flush),
    .stall_req    (stall_req),
    .result       (result),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op at #1 after a rising edge, hold it while stall_req is high,
  // and return with inputs idle, #1 after the edge that completes it.
  task automatic exec(input logic [5:0] f, input logic sp2, input logic [31:0] a,
                      input logic [31:0] b, output int ns);
    valid     = 1'b1;
    funct     = f;
    special2  = sp2;
    operand_1 = a;
    operand_2 = b;
    ns = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stall_req) ns++;
      else break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    valid    = 1'b0;
    funct    = 6'h00;
    special2 = 1'b0;
  endtask

  initial begin
    int ns;
    logic [31:0] lo_keep;

    vecs[0] = '{6'h18, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 3};
    vecs[1] = '{6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32};
    vecs[2] = '{6'h1B, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 32};
    vecs[3] = '{6'h1B, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 0};
    vecs[4] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32};
    vecs[5] = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3};
    vecs[6] = '{6'h11, 32'h12345678, 32'd0,        32'h12345678, 32'h00000001, 0};
    vecs[7] = '{6'h13, 32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 0};
    vecs[8] = '{6'h1A, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 32};
    vecs[9] = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3};

    rst_n = 1'b0; valid = 1'b0; funct = 6'h00; special2 = 1'b0;
    operand_1 = '0; operand_2 = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state through MFHI / MFLO
    valid = 1'b1; funct = 6'h10;
    @(negedge clk);
    check("rst_mfhi_result", 64'(result), 64'h0);
    check("rst_mfhi_rvalid", 64'(result_valid), 64'h1);
    check("rst_mfhi_stall",  64'(stall_req), 64'h0);
    funct = 6'h12;
    #1;
    check("rst_mflo_result", 64'(result), 64'h0);
    check("rst_mflo_rvalid", 64'(result_valid), 64'h1);
    check("rst_mflo_stall",  64'(stall_req), 64'h0);
    @(posedge clk);
    #1 valid = 1'b0; funct = 6'h00;

    // Table of single ops, results chained through HI/LO
    for (int k = 0; k < 10; k++) begin
      exec(vecs[k].f, 1'b0, vecs[k].a, vecs[k].b, ns);
      check($sformatf("vec%0d_stall", k), 64'(ns), 64'(vecs[k].exp_stall));
      check($sformatf("vec%0d_hi", k), 64'(hi), 64'(vecs[k].exp_hi));
      check($sformatf("vec%0d_lo", k), 64'(lo), 64'(vecs[k].exp_lo));
    end

    // Back-to-back: MTLO then MFLO in the very next cycle
    valid = 1'b1; funct = 6'h13; operand_1 = 32'hA5A5A5A5;
    @(posedge clk);
    #1 funct = 6'h12;
    @(negedge clk);
    check("b2b_mflo_result", 64'(result), 64'hA5A5A5A5);
    check("b2b_mflo_rvalid", 64'(result_valid), 64'h1);
    @(posedge clk);
    #1 valid = 1'b0; funct = 6'h00;

    // Non-member funct: no stall, no result, HI/LO unchanged
    valid = 1'b1; funct = 6'h20; operand_1 = 32'hDEADBEEF; operand_2 = 32'd3;
    @(negedge clk);
    check("nonmember_stall",  64'(stall_req), 64'h0);
    check("nonmember_result", 64'(result), 64'h0);
    check("nonmember_rvalid", 64'(result_valid), 64'h0);
    @(posedge clk);
    #1 valid = 1'b0; funct = 6'h00;
    check("nonmember_hilo", {hi, lo}, {32'h40000000, 32'hA5A5A5A5});

    // Flush in the second cycle of a MULTU keeps HI/LO
    exec(6'h11, 1'b0, 32'h12345678, 32'd0, ns);
    lo_keep = lo;
    valid = 1'b1; funct = 6'h19; operand_1 = 32'd3; operand_2 = 32'd3;
    @(negedge clk);
    check("flush_cyc1_stall", 64'(stall_req), 64'h1);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_cyc2_stall", 64'(stall_req), 64'h0);
    @(posedge clk);
    #1 flush = 1'b0; valid = 1'b0; funct = 6'h00;
    check("flush_hilo_kept", {hi, lo}, {32'h12345678, lo_keep});
    valid = 1'b1; funct = 6'h10;
    @(negedge clk);
    check("flush_mfhi_result", 64'(result), 64'h12345678);
    check("flush_idle_stall",  64'(stall_req), 64'h0);
    @(posedge clk);
    #1 valid = 1'b0; funct = 6'h00;
    repeat (4) @(posedge clk);
    #1;
    check("flush_hilo_later", {hi, lo}, {32'h12345678, lo_keep});
    exec(6'h19, 1'b0, 32'd3, 32'd3, ns);
    check("post_flush_multu_stall", 64'(ns), 64'd3);
    check("post_flush_multu_hilo", {hi, lo}, 64'd9);

    // SPECIAL2 MADDU 1*1 onto hi=0, lo=all-ones
    exec(6'h11, 1'b0, 32'h0, 32'd0, ns);
    exec(6'h13, 1'b0, 32'hFFFFFFFF, 32'd0, ns);
    exec(6'h01, 1'b1, 32'd1, 32'd1, ns);
`ifdef MULDIV_MADD_EN
    check("maddu_stall", 64'(ns), 64'd3);
    check("maddu_hilo", {hi, lo}, {32'h00000001, 32'h00000000});
`else
    check("maddu_off_stall", 64'(ns), 64'd0);
    check("maddu_off_hilo", {hi, lo}, {32'h00000000, 32'hFFFFFFFF});
`endif

    // Asynchronous reset in the middle of a DIV
    valid = 1'b1; funct = 6'h1B; operand_1 = 32'd100; operand_2 = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    check("midop_stall_before", 64'(stall_req), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midop_rst_stall", 64'(stall_req), 64'h0);
    check("midop_rst_hilo", {hi, lo}, 64'h0);
    valid = 1'b0; funct = 6'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exec(6'h1B, 1'b0, 32'd100, 32'd7, ns);
    check("after_rst_divu_stall", 64'(ns), 64'd32);
    check("after_rst_divu_hilo", {hi, lo}, {32'd2, 32'd14});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
